// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU function codes and the internal aluop selector.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // 3'b011 and 3'b101 are reserved ALU codes and never generated here.
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and the R-type funct field to the ALU F code, and
// flags whether funct names a supported operation (independent of aluop).
module mc_aludec
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_f;

  always_comb begin
    funct_valid_o = 1'b1;
    funct_f       = AluAdd;
    case (funct_i)
      FunctAdd: funct_f = AluAdd;
      FunctSub: funct_f = AluSub;
      FunctAnd: funct_f = AluAnd;
      FunctOr:  funct_f = AluOr;
      FunctSlt: funct_f = AluSlt;
      default: begin
        funct_f       = AluAdd;
        funct_valid_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (aluop_i)
      AluOpSub:   alucontrol_o = AluSub;
      AluOpFunct: alucontrol_o = funct_f;
      default:    alucontrol_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with combinational output decode,
// ALU function decode and branch-qualified PC enable.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned STATEW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  output logic [2:0]        alucontrol,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic              iord,
  output logic              memtoreg,
  output logic              regdst,
  output logic              irwrite,
  output logic              memwrite,
  output logic              regwrite,
  output logic              pcen,
  output logic [STATEW-1:0] state
);

  state_e     state_q, state_d, dec_st;
  logic       funct_ok_q, funct_ok_d;
  logic       funct_valid;
  logic [1:0] aluop;
  logic       pcwrite, branch, irw, memw, regw;

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .funct_valid_o(funct_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      funct_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct_ok_q <= funct_ok_d;
    end
  end

  // Remember funct validity at execute so the writeback can veto regwrite.
  assign funct_ok_d = (state_q == StRtypeEx) ? funct_valid : funct_ok_q;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (op == OpLw)      state_d = StMemRd;
        else if (op == OpSw) state_d = StMemWr;
        else                 state_d = StFetch;
      end
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // While reset is held the datapath sees FETCH decode with all writes masked.
  assign dec_st = reset ? StFetch : state_q;

  always_comb begin
    aluop    = AluOpAdd;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    irw      = 1'b0;
    memw     = 1'b0;
    regw     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (dec_st)
      StFetch: begin
        irw     = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr, StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        regw     = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        iord = 1'b1;
        memw = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRtypeWb: begin
        regw   = funct_ok_q;
        regdst = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        aluop   = AluOpSub;
      end
      StAddiWb: regw = 1'b1;
      StJEx: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign irwrite  = irw & ~reset;
  assign memwrite = memw & ~reset;
  assign regwrite = regw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = STATEW'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-instruction state paths and per-state
// control words from a table-driven reference model, with random reset hits.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca, iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_controller #(.STATEW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .alucontrol(alucontrol),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .iord      (iord),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .pcen      (pcen),
    .state     (state)
  );

  always #5 clk = ~clk;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Instruction-level view: which states an instruction walks through.
  function automatic void build_path(input logic [5:0] o, output int p[$]);
    p = {FETCH, DECODE};
    case (o)
      6'b100011: p = {p, MEMADR, MEMRD, MEMWB};
      6'b101011: p = {p, MEMADR, MEMWR};
      6'b000000: p = {p, RTYPEEX, RTYPEWB};
      6'b000100: p = {p, BEQEX};
      6'b001000: p = {p, ADDIEX, ADDIWB};
      6'b000010: p = {p, JEX};
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit funct_known(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Packed {alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
  //         irwrite, memwrite, regwrite, pcen}
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] f, input logic z,
                                          input logic rst);
    logic [2:0] alu = 3'b010;
    logic       sa = 0, io = 0, m2r = 0, rd = 0, irw = 0, mw = 0, rw = 0, pcw = 0, br = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    int s = rst ? FETCH : st;
    case (s)
      FETCH:   begin irw = 1; pcw = 1; sb = 2'b01; end
      DECODE:  sb = 2'b11;
      MEMADR, ADDIEX: begin sa = 1; sb = 2'b10; end
      MEMRD:   io = 1;
      MEMWB:   begin rw = 1; m2r = 1; end
      MEMWR:   begin io = 1; mw = 1; end
      RTYPEEX: begin sa = 1; alu = funct_alu(f); end
      RTYPEWB: begin rw = funct_known(f); rd = 1; end
      BEQEX:   begin sa = 1; br = 1; ps = 2'b01; alu = 3'b110; end
      ADDIWB:  rw = 1;
      JEX:     begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (rst) begin irw = 0; mw = 0; rw = 0; pcw = 0; br = 0; end
    return {alu, sa, sb, ps, io, m2r, rd, irw, mw, rw, pcw | (br & z)};
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
            irwrite, memwrite, regwrite, pcen};
  endfunction

  // Directed opening: LW, R sub/and/or/slt, BEQ z=1/z=0, bad op, bad funct,
  // LW reset in MEMRD, J.
  localparam int NDIR = 11;
  logic [5:0] d_op   [NDIR] = '{6'b100011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000100, 6'b000100, 6'b111111, 6'b000000, 6'b100011,
                                6'b000010};
  logic [5:0] d_fn   [NDIR] = '{6'b0, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b0, 6'b0, 6'b0, 6'b000001, 6'b0, 6'b0};
  logic       d_zero [NDIR] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int         d_rst  [NDIR] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 3, -1};

  function automatic logic [5:0] rand_op();
    logic [5:0] known [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                             6'b000010};
    logic [5:0] o;
    if ($urandom_range(0, 7) != 0) return known[$urandom_range(0, 5)];
    do o = 6'($urandom_range(0, 63)); while (o inside {known});
    return o;
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] known [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 3) != 0) return known[$urandom_range(0, 4)];
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    int  path[$];
    int  rst_at;
    bit  rnd;
    reset = 1'b1;
    op    = 6'b0;
    funct = 6'b0;
    zero  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reset_state", 32'(state), FETCH);
    check_eq("reset_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(FETCH, funct, zero, 1'b1)));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      rnd    = (n >= NDIR);
      op     = rnd ? rand_op() : d_op[n];
      funct  = rnd ? rand_funct() : d_fn[n];
      rst_at = rnd ? -1 : d_rst[n];
      build_path(op, path);
      check_eq("path_latency", 32'(path.size()), 32'(latency(op)));
      for (int i = 0; i < path.size(); i++) begin
        zero  = rnd ? 1'($urandom_range(0, 1)) : d_zero[n];
        reset = (i == rst_at) || (rnd && $urandom_range(0, 59) == 0);
        @(negedge clk);
        check_eq($sformatf("state[n%0d,c%0d]", n, i), 32'(state), 32'(path[i]));
        check_eq($sformatf("ctrl[n%0d,c%0d,st%0d]", n, i, path[i]), 32'(obs_ctrl()),
                 32'(exp_ctrl(path[i], funct, zero, reset)));
        if (path[i] == BEQEX && !reset) begin
          zero = ~zero;
          #1;
          check_eq("beq_pcen_follows_zero", 32'(pcen), 32'(zero));
        end
        @(posedge clk); #1;
        if (reset) begin
          reset = 1'b0;
          check_eq("post_reset_state", 32'(state), FETCH);
          break;
        end
      end
    end
    @(negedge clk);
    check_eq("final_state", 32'(state), FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Control unit for the multicycle MIPS datapath. It sits on the opposite side of the ALU's F/Zero interface. It decodes op/funct, runs the multicycle Moore FSM, drives the 3-bit ALU function code and all datapath enables, and consumes the ALU Zero flag to form the PC enable for branches. Instance sits beside the datapath in the processor top level.

Parameters:
STATEW, 4, width of the internal state register (12 states used).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
op  input  6  instruction opcode (instr[31:26]) from IR
funct  input  6  function field (instr[5:0]) from IR
zero  input  1  ALU Zero flag (Y == 0)
alucontrol  output  3  ALU function code F[2:0]
alusrca  output  1  0=PC, 1=register A
alusrcb  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
iord  output  1  memory address: 0=PC, 1=ALUOut
memtoreg  output  1  register write data: 0=ALUOut, 1=Data
regdst  output  1  destination register: 0=rt, 1=rd
irwrite, memwrite, regwrite  output  1 each  write enables
pcen  output  1  pcwrite | (branch & zero)
state  output  STATEW  current state, for debug/verification

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. On the clk edge with reset=1, state <= FETCH.
- Outputs are Moore, decoded combinationally from state. Exception: pcen also depends on zero.
- While reset=1, irwrite, memwrite, regwrite and pcen are forced to 0. Other outputs follow FETCH decode.
- States, encoded 0..11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Transitions:
  - FETCH->DECODE.
  - DECODE, by op: LW/SW->MEMADR; RTYPE->RTYPEEX; BEQ->BEQEX; ADDI->ADDIEX; J->JEX; any other op->FETCH (instruction treated as NOP, no write enables).
  - MEMADR: LW->MEMRD, SW->MEMWR.
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Per-state asserted signals (unlisted = 0):
  - FETCH: irwrite, pcwrite, alusrcb=01, aluop=ADD.
  - DECODE: alusrcb=11, aluop=ADD.
  - MEMADR, ADDIEX: alusrca, alusrcb=10, aluop=ADD.
  - MEMRD: iord.
  - MEMWB: regwrite, memtoreg.
  - MEMWR: iord, memwrite.
  - RTYPEEX: alusrca, aluop=FUNCT.
  - RTYPEWB: regwrite, regdst.
  - BEQEX: alusrca, branch, pcsrc=01, aluop=SUB.
  - ADDIWB: regwrite.
  - JEX: pcwrite, pcsrc=10.
- ALU decode:
  - aluop ADD -> 010.
  - aluop SUB -> 110.
  - aluop FUNCT, by funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other -> 010, and regwrite is suppressed in the following RTYPEWB. An unknown funct must never write the register file.
- Latencies in cycles, FETCH to FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, unknown op 2.
- pcen is valid in the same cycle as zero. Within BEQEX, a zero change causes a combinational pcen change.
- reset asserted in any state overrides all transitions; FETCH is entered at that edge.
- Instruction fields are sampled combinationally every cycle; the IR holds them stable outside FETCH.

Decomposition:
- Shared package holds:
  - state encodings
  - opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010
  - funct codes
  - ALU F codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111, plus 011/101 reserved
  - aluop encoding: ADD 00, SUB 01, FUNCT 10
- One natural sub-module: mc_aludec, combinational aluop+funct -> alucontrol, funct_valid.
- The FSM, output decode and pcen logic stay in mc_controller.

Test Plan:
- LW (op=100011), reset released → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. alucontrol=010 in MEMADR; memtoreg=1 and regwrite=1 only in MEMWB.
- R-type sub (funct=100010) → alucontrol=110 and alusrca=1 in RTYPEEX. Then regwrite=1 and regdst=1 in RTYPEWB. Repeat for and/or/slt → 000/001/111.
- BEQ: with zero=1 in BEQEX → pcen=1, pcsrc=01, alucontrol=110. With zero=0 → pcen=0. Next state is FETCH in both cases.
- Unknown op 111111 → DECODE then FETCH, with no write enable asserted. Unknown funct 000001 → regwrite=0 in RTYPEWB.
- Reset pulse while in MEMRD → FETCH on the next edge. All write enables are 0 during the reset cycle, and FETCH outputs resume after release.
- J (op=000010) → JEX with pcsrc=10 and pcen=1 → FETCH. Total 3 cycles.
